svn_scan_ctrl: RTL

//   Time-multiplexed scan controller for the 8-digit common-anode 7-segment display.

---
 rtl/svn_scan_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/svn_scan_ctrl.sv
// Multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Optional anti-ghosting dead time at the start of each slot when SEG_BLANK_EN is defined.
module svn_scan_ctrl #(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [3:0]              bcd,
  output logic                    dp_in,
  output logic [7:0]              AN,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // Dead time collapses to zero cycles when the blanking feature is not built in.
  localparam int unsigned BLANK_EFF =
`ifdef SEG_BLANK_EN
    BLANK_CYC;
`else
    BLANK_CYC * 0;
`endif

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          shadow_nib [N_DIGITS];
  logic [N_DIGITS-1:0] shadow_dp;
  logic                slot_end;
  logic                frame_end;
  logic                load;
  logic                blank;
  logic [7:0]          an_sel;

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = en && slot_end && (idx == IDX_W'(N_DIGITS - 1));
  // While dark the shadow can be refreshed at any time without visible tearing.
  assign load      = upd_req && (frame_end || !en);

  generate
    if (BLANK_EFF > 0) begin : g_blank
      assign blank = (cnt < CNT_W'(BLANK_EFF));
    end else begin : g_no_blank
      assign blank = 1'b0;
    end
  endgenerate

  always_comb begin
    an_sel = 8'hFF;
    if (digit_en[idx] && !blank) an_sel[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_dp  <= '0;
      for (int i = 0; i < N_DIGITS; i++) shadow_nib[i] <= 4'hF;
      AN         <= 8'hFF;
      bcd        <= 4'hF;
      dp_in      <= 1'b0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      upd_ack    <= load;
      frame_tick <= frame_end;
      if (load) begin
        for (int i = 0; i < N_DIGITS; i++) shadow_nib[i] <= data[4*i +: 4];
        shadow_dp <= dp_mask;
      end
      if (!en) begin
        cnt <= '0;
        idx <= '0;
        AN  <= 8'hFF;
      end else begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        AN <= an_sel;
      end
      bcd   <= shadow_nib[idx];
      dp_in <= shadow_dp[idx];
    end
  end

endmodule
